// File: rtl/dab_phase_modulator.sv
// rtl/dab_phase_modulator.sv - DAB three-level modulator with buffered parameters, validation and dead time
// Outputs decode the next-state count so V, gates and period_start line up with the c1 they represent.
module dab_phase_modulator #(
  parameter int CW  = 20,
  parameter int DTW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 sync_i,
  input  logic                 load_i,
  input  logic [CW-1:0]        half_per_i,
  input  logic [CW-1:0]        tau1_i,
  input  logic [CW-1:0]        tau2_i,
  input  logic signed [CW:0]   phi_i,
  input  logic [DTW-1:0]       deadtime_i,
  output logic signed [1:0]    v1_o,
  output logic signed [1:0]    v2_o,
  output logic [3:0]           sp_o,
  output logic [3:0]           ss_o,
  output logic                 period_start_o,
  output logic                 running_o,
  output logic                 fault_o
);

  localparam int XW = CW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

  typedef struct packed {
    logic [CW-1:0]  n;
    logic [CW-1:0]  t1;
    logic [CW-1:0]  t2;
    logic [CW:0]    phi;
    logic [DTW-1:0] dt;
  } param_t;

  state_t              state_q, state_d;
  param_t              pend_q, pend_d, act_q, act_d, in_set;
  logic                dirty_q, dirty_d, act_valid_q, act_valid_d;
  logic [CW:0]         c1_q, c1_d, last_c, c2;
  logic                pend_ok, xfer, run_d, leg_edge, leg_on;
  logic signed [XW-1:0] c2s, two_n;
  logic [3:0]          cmd_q, cmd_d, hi, lo;
  logic [3:0][DTW-1:0] w_q, w_d;
  logic signed [1:0]   v1_q, v2_q;
  logic [3:0]          sp_q, ss_q;
  logic                ps_q, run_q, fault_q;

  function automatic logic set_valid(input param_t p);
    logic signed [XW-1:0] ns, ps;
    ns = signed'({2'b00, p.n});
    ps = XW'($signed(p.phi));
    return (p.n >= CW'(2)) && (p.t1 <= p.n) && (p.t2 <= p.n) && (ps <= ns) && (ps >= -ns);
  endfunction

  // Returns {B_cmd, A_cmd} for one bridge.
  function automatic logic [1:0] leg_cmd(input logic [CW:0] c, input logic [CW-1:0] n,
                                         input logic [CW-1:0] tau);
    logic [CW:0] nn, tt;
    logic a, b;
    nn = {1'b0, n};
    tt = {1'b0, tau};
    a  = (c >= nn - tt) && (c < {n, 1'b0} - tt);
    b  = (c >= nn);
    return {b, a};
  endfunction

  function automatic logic signed [1:0] volts(input logic [1:0] ba);
    case (ba)
      2'b01:   return 2'sb01;
      2'b10:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  assign in_set  = {half_per_i, tau1_i, tau2_i, phi_i, deadtime_i};
  assign pend_ok = set_valid(pend_q);
  assign last_c  = {act_q.n, 1'b0} - (CW+1)'(1);

  always_comb begin
    state_d     = state_q;
    c1_d        = c1_q;
    pend_d      = pend_q;
    act_d       = act_q;
    dirty_d     = dirty_q;
    act_valid_d = act_valid_q;
    xfer        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sync_i) begin
          if (dirty_q ? !pend_ok : !act_valid_q) begin
            state_d = S_FAULT;
          end else if (en_i) begin
            state_d = S_RUN;
            c1_d    = '0;
            xfer    = dirty_q;
          end
        end
      end
      S_RUN: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else if (c1_q == last_c) begin
          c1_d = '0;
          if (dirty_q) begin
            if (pend_ok) xfer = 1'b1;
            else         state_d = S_FAULT;
          end
        end else begin
          c1_d = c1_q + (CW+1)'(1);
        end
      end
      default: ;
    endcase
    if (xfer) begin
      act_d       = pend_q;
      act_valid_d = 1'b1;
      dirty_d     = 1'b0;
    end
    // A load coinciding with a transfer lands in pending and waits for the next wrap.
    if (load_i && state_q != S_FAULT) begin
      pend_d  = in_set;
      dirty_d = 1'b1;
    end
  end

  always_comb begin
    run_d    = (state_d == S_RUN);
    two_n    = signed'({1'b0, act_d.n, 1'b0});
    c2s      = signed'({1'b0, c1_d}) - XW'($signed(act_d.phi));
    if (c2s < 0)           c2s = c2s + two_n;
    else if (c2s >= two_n) c2s = c2s - two_n;
    c2       = c2s[CW:0];
    cmd_d    = {leg_cmd(c2, act_d.n, act_d.t2), leg_cmd(c1_d, act_d.n, act_d.t1)};
    w_d      = w_q;
    hi       = '0;
    lo       = '0;
    leg_edge = 1'b0;
    leg_on   = 1'b0;
    // Entry into RUN counts as a command edge so the first gate also waits out the dead time.
    for (int i = 0; i < 4; i++) begin
      leg_edge = run_d && ((state_q != S_RUN) || (cmd_d[i] != cmd_q[i]));
      if (leg_edge)           w_d[i] = act_d.dt;
      else if (w_q[i] != '0)  w_d[i] = w_q[i] - DTW'(1);
      else                    w_d[i] = '0;
      leg_on = run_d && (w_d[i] == '0);
      hi[i]  = leg_on && cmd_d[i];
      lo[i]  = leg_on && !cmd_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      act_q       <= '0;
      dirty_q     <= 1'b0;
      act_valid_q <= 1'b0;
      c1_q        <= '0;
      cmd_q       <= '0;
      w_q         <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      sp_q        <= '0;
      ss_q        <= '0;
      ps_q        <= 1'b0;
      run_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      dirty_q     <= dirty_d;
      act_valid_q <= act_valid_d;
      c1_q        <= c1_d;
      cmd_q       <= cmd_d;
      w_q         <= w_d;
      v1_q        <= run_d ? volts(cmd_d[1:0]) : 2'sb00;
      v2_q        <= run_d ? volts(cmd_d[3:2]) : 2'sb00;
      sp_q        <= {lo[1], hi[1], lo[0], hi[0]};
      ss_q        <= {lo[3], hi[3], lo[2], hi[2]};
      ps_q        <= run_d && (c1_d == '0);
      run_q       <= run_d;
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign v1_o           = v1_q;
  assign v2_o           = v2_q;
  assign sp_o           = sp_q;
  assign ss_o           = ss_q;
  assign period_start_o = ps_q;
  assign running_o      = run_q;
  assign fault_o        = fault_q;

endmodule
